// File: rtl/max19506_pkg.sv
// Shared types and helpers for the MAX19506 receive path.
package max19506_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              or_a;
    logic              or_b;
  } pair_t;

  typedef enum logic {
    WAIT_A = 1'b0,
    HAVE_A = 1'b1
  } pair_state_e;

  // Offset binary to two's complement is a flip of the sign bit.
  function automatic logic [DATA_W-1:0] to_out_fmt(input logic [DATA_W-1:0] w,
                                                   input logic              twos);
    return {w[DATA_W-1] ^ twos, w[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/adc_pair_fifo.sv
// Synchronous show-ahead FIFO of ADC sample pairs with occupancy and drop strobe.
module adc_pair_fifo
  import max19506_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  pair_t                  push_pair_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output pair_t                  head_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  pair_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic           pop_c;
  logic           full_c;
  logic           push_ok_c;

  // A pop frees a slot in the same edge, so a full FIFO still takes a push then.
  always_comb begin
    pop_c     = pop_i && (level_q != '0);
    full_c    = (level_q == LW'(DEPTH));
    push_ok_c = push_i && (!full_c || pop_c);
    drop_c_o  = push_i && full_c && !pop_c;
    level_d   = level_q;
    case ({push_ok_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok_c) wr_q <= wr_q + AW'(1);
      if (pop_c)     rd_q <= rd_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_q] <= push_pair_i;
  end

  assign valid_o = (level_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/max19506_rx.sv
// MAX19506 ADC capture: input stage, parallel/mux pairing, output FIFO, status counters.
module max19506_rx
  import max19506_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        adc_strb,
  input  logic [DATA_W-1:0]           adc_da,
  input  logic [DATA_W-1:0]           adc_db,
  input  logic                        adc_dora,
  input  logic                        adc_dorb,
  input  logic                        adc_chsel,
  input  logic                        en,
  input  logic                        cfg_mux,
  input  logic                        cfg_twos,
  input  logic                        clr_cnt,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_a,
  output logic [DATA_W-1:0]           m_b,
  output logic [1:0]                  m_or,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            or_cnt_a,
  output logic [CNT_W-1:0]            or_cnt_b,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic [CNT_W-1:0]            sync_err_cnt
);

  logic              stg_vld_q;
  logic [DATA_W-1:0] stg_da_q;
  logic [DATA_W-1:0] stg_db_q;
  logic              stg_dora_q;
  logic              stg_dorb_q;
  logic              stg_chsel_q;

  pair_state_e       state_q, state_d;
  logic [DATA_W-1:0] held_a_q, held_a_d;
  logic              held_or_q, held_or_d;
  logic              mux_q;

  logic              push_c;
  pair_t             pair_c;
  logic              sync_err_c;
  logic              flush_c;
  logic [DATA_W-1:0] word_c;
  logic              drop_c;
  pair_t             head;

  logic [CNT_W-1:0]  or_cnt_a_q, or_cnt_b_q, drop_cnt_q, sync_err_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Input stage: one registered copy of each accepted word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_vld_q   <= 1'b0;
      stg_da_q    <= '0;
      stg_db_q    <= '0;
      stg_dora_q  <= 1'b0;
      stg_dorb_q  <= 1'b0;
      stg_chsel_q <= 1'b0;
    end else begin
      stg_vld_q <= adc_strb && en;
      if (adc_strb && en) begin
        stg_da_q    <= adc_da;
        stg_db_q    <= adc_db;
        stg_dora_q  <= adc_dora;
        stg_dorb_q  <= adc_dorb;
        stg_chsel_q <= adc_chsel;
      end
    end
  end

  // Pairer: a disable or a mode switch drops any held A silently.
  always_comb begin
    state_d    = state_q;
    held_a_d   = held_a_q;
    held_or_d  = held_or_q;
    push_c     = 1'b0;
    pair_c     = '0;
    sync_err_c = 1'b0;
    word_c     = to_out_fmt(stg_da_q, cfg_twos);
    flush_c    = !en || (cfg_mux != mux_q);

    if (!cfg_mux) begin
      state_d     = WAIT_A;
      held_a_d    = '0;
      held_or_d   = 1'b0;
      push_c      = stg_vld_q;
      pair_c.a    = word_c;
      pair_c.b    = to_out_fmt(stg_db_q, cfg_twos);
      pair_c.or_a = stg_dora_q;
      pair_c.or_b = stg_dorb_q;
    end else if (flush_c) begin
      state_d   = WAIT_A;
      held_a_d  = '0;
      held_or_d = 1'b0;
    end else if (stg_vld_q) begin
      case (state_q)
        WAIT_A: begin
          if (stg_chsel_q) begin
            held_a_d  = word_c;
            held_or_d = stg_dora_q;
            state_d   = HAVE_A;
          end else begin
            sync_err_c = 1'b1;
          end
        end
        HAVE_A: begin
          if (stg_chsel_q) begin
            held_a_d   = word_c;
            held_or_d  = stg_dora_q;
            sync_err_c = 1'b1;
          end else begin
            push_c      = 1'b1;
            pair_c.a    = held_a_q;
            pair_c.b    = word_c;
            pair_c.or_a = held_or_q;
            pair_c.or_b = stg_dora_q;
            state_d     = WAIT_A;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT_A;
      held_a_q  <= '0;
      held_or_q <= 1'b0;
      mux_q     <= cfg_mux;
    end else begin
      state_q   <= state_d;
      held_a_q  <= held_a_d;
      held_or_q <= held_or_d;
      mux_q     <= cfg_mux;
    end
  end

  adc_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .push_pair_i (pair_c),
    .pop_i       (m_ready),
    .valid_o     (m_valid),
    .head_o      (head),
    .level_o     (fifo_level),
    .drop_c_o    (drop_c)
  );

  // Status counters saturate; clear beats any same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset || clr_cnt) begin
      or_cnt_a_q     <= '0;
      or_cnt_b_q     <= '0;
      drop_cnt_q     <= '0;
      sync_err_cnt_q <= '0;
    end else begin
      or_cnt_a_q     <= sat_inc(or_cnt_a_q, push_c && pair_c.or_a);
      or_cnt_b_q     <= sat_inc(or_cnt_b_q, push_c && pair_c.or_b);
      drop_cnt_q     <= sat_inc(drop_cnt_q, drop_c);
      sync_err_cnt_q <= sat_inc(sync_err_cnt_q, sync_err_c);
    end
  end

  assign m_a          = head.a;
  assign m_b          = head.b;
  assign m_or         = {head.or_b, head.or_a};
  assign or_cnt_a     = or_cnt_a_q;
  assign or_cnt_b     = or_cnt_b_q;
  assign drop_cnt     = drop_cnt_q;
  assign sync_err_cnt = sync_err_cnt_q;

endmodule

// File: tb/tb_max19506_rx.sv
// Directed bench for max19506_rx with hand-computed expectations.
module tb_max19506_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       adc_strb;
  logic [7:0] adc_da, adc_db;
  logic       adc_dora, adc_dorb, adc_chsel;
  logic       en, cfg_mux, cfg_twos, clr_cnt;
  logic       m_valid, m_ready;
  logic [7:0] m_a, m_b;
  logic [1:0] m_or;
  logic [2:0] fifo_level;
  logic [CW-1:0] or_cnt_a, or_cnt_b, drop_cnt, sync_err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  max19506_rx #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .adc_strb     (adc_strb),
    .adc_da       (adc_da),
    .adc_db       (adc_db),
    .adc_dora     (adc_dora),
    .adc_dorb     (adc_dorb),
    .adc_chsel    (adc_chsel),
    .en           (en),
    .cfg_mux      (cfg_mux),
    .cfg_twos     (cfg_twos),
    .clr_cnt      (clr_cnt),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_a          (m_a),
    .m_b          (m_b),
    .m_or         (m_or),
    .fifo_level   (fifo_level),
    .or_cnt_a     (or_cnt_a),
    .or_cnt_b     (or_cnt_b),
    .drop_cnt     (drop_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] da, input logic [7:0] db,
                        input logic ora, input logic orb, input logic chsel);
    adc_da    = da;
    adc_db    = db;
    adc_dora  = ora;
    adc_dorb  = orb;
    adc_chsel = chsel;
    adc_strb  = 1'b1;
    tick();
    adc_strb  = 1'b0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    reset = 1'b0; adc_strb = 1'b0; adc_da = '0; adc_db = '0;
    adc_dora = 1'b0; adc_dorb = 1'b0; adc_chsel = 1'b0;
    en = 1'b1; cfg_mux = 1'b0; cfg_twos = 1'b0; clr_cnt = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_m_a", 32'(m_a), 0);
    check("rst_or_cnt_a", 32'(or_cnt_a), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_sync", 32'(sync_err_cnt), 0);
    reset = 1'b1;
    tick();

    // Parallel, two's complement, two-edge latency.
    cfg_twos = 1'b1;
    strobe(8'h80, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("lat_edge0_valid", 32'(m_valid), 0);
    tick();
    check("lat_edge1_valid", 32'(m_valid), 1);
    check("twos_m_a", 32'(m_a), 32'h00);
    check("twos_m_b", 32'(m_b), 32'h7F);
    tick();
    check("popped_valid", 32'(m_valid), 0);
    check("popped_m_b_zero", 32'(m_b), 0);

    // Parallel, offset binary passthrough, A overrange.
    cfg_twos = 1'b0;
    strobe(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    tick();
    check("par_m_a", 32'(m_a), 32'h12);
    check("par_m_b", 32'(m_b), 32'h34);
    check("par_m_or", 32'(m_or), 32'h1);
    check("par_or_cnt_a", 32'(or_cnt_a), 1);
    check("par_or_cnt_b", 32'(or_cnt_b), 0);
    tick();
    clear_counters();
    check("clr_or_cnt_a", 32'(or_cnt_a), 0);

    // Mux mode: A then B forms one pair.
    cfg_mux = 1'b1; m_ready = 1'b0;
    tick();
    strobe(8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
    strobe(8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("mux_valid", 32'(m_valid), 1);
    check("mux_m_a", 32'(m_a), 32'h10);
    check("mux_m_b", 32'(m_b), 32'h20);
    check("mux_level", 32'(fifo_level), 1);
    check("mux_sync0", 32'(sync_err_cnt), 0);
    m_ready = 1'b1; tick(); m_ready = 1'b0;

    // B,A,A,B: two sync errors, pair keeps the second A.
    strobe(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    strobe(8'h0A, 8'h00, 1'b0, 1'b0, 1'b1);
    strobe(8'h0B, 8'h00, 1'b0, 1'b0, 1'b1);
    strobe(8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("baab_sync", 32'(sync_err_cnt), 2);
    check("baab_level", 32'(fifo_level), 1);
    check("baab_m_a", 32'(m_a), 32'h0B);
    check("baab_m_b", 32'(m_b), 32'h0C);
    m_ready = 1'b1; tick(); m_ready = 1'b0;

    // en dropped while holding A: A discarded silently, next B is an error.
    strobe(8'h55, 8'h00, 1'b0, 1'b0, 1'b1);
    en = 1'b0; tick(); en = 1'b1;
    strobe(8'h66, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("en_flush_sync", 32'(sync_err_cnt), 3);
    check("en_flush_level", 32'(fifo_level), 0);

    // Reset with HAVE_A and two pairs queued.
    strobe(8'h21, 8'h00, 1'b0, 1'b0, 1'b1);
    strobe(8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    strobe(8'h23, 8'h00, 1'b0, 1'b0, 1'b1);
    strobe(8'h24, 8'h00, 1'b0, 1'b0, 1'b0);
    strobe(8'h25, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    check("pre_rst_level", 32'(fifo_level), 2);
    check("pre_rst_sync", 32'(sync_err_cnt), 3);
    reset = 1'b0; tick(); reset = 1'b1;
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_m_a", 32'(m_a), 0);
    check("mid_rst_sync", 32'(sync_err_cnt), 0);
    strobe(8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("post_rst_b_err", 32'(sync_err_cnt), 1);
    check("post_rst_level", 32'(fifo_level), 0);

    // Overflow: DEPTH+3 strobes with no pops.
    cfg_mux = 1'b0;
    tick();
    for (int i = 0; i < DEPTH + 3; i++) strobe(8'(8'h40 + i), 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    tick();
    check("ovf_level", 32'(fifo_level), DEPTH);
    check("ovf_drop", 32'(drop_cnt), 3);
    check("ovf_head", 32'(m_a), 32'h40);
    strobe(8'h50, 8'h90, 1'b0, 1'b0, 1'b0);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    check("full_pushpop_level", 32'(fifo_level), DEPTH);
    check("full_pushpop_drop", 32'(drop_cnt), 3);
    check("full_pushpop_head", 32'(m_a), 32'h41);
    m_ready = 1'b1;
    tick(); tick(); tick();
    check("drain_tail_a", 32'(m_a), 32'h50);
    check("drain_tail_b", 32'(m_b), 32'h90);
    tick();
    check("drain_level", 32'(fifo_level), 0);
    check("drain_valid", 32'(m_valid), 0);

    // Clear coincident with the 5th overrange pair wins.
    clear_counters();
    for (int i = 0; i < 5; i++) strobe(8'(i), 8'h00, 1'b1, 1'b0, 1'b0);
    check("or_before_clr", 32'(or_cnt_a), 4);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    check("or_clr_wins", 32'(or_cnt_a), 0);
    check("drop_cleared", 32'(drop_cnt), 0);

    // Saturation of the 4-bit overrange counter.
    for (int i = 0; i < 15; i++) strobe(8'(i), 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("or_at_max", 32'(or_cnt_a), 15);
    strobe(8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("or_saturated", 32'(or_cnt_a), 15);
    check("or_b_idle", 32'(or_cnt_b), 0);

    // Strobe ignored while disabled.
    tick();
    en = 1'b0;
    strobe(8'h77, 8'h77, 1'b1, 1'b1, 1'b0);
    tick();
    check("dis_level", 32'(fifo_level), 0);
    check("dis_valid", 32'(m_valid), 0);
    check("dis_or_b", 32'(or_cnt_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/max19506_rx.md
MAX19506_RX -- requirements
Module: max19506_rx

Interface
REQ-001 The block SHALL have a parameter FIFO_DEPTH, default 4, giving the output FIFO depth in sample pairs (power of two, 2..16).
REQ-002 The block SHALL have a parameter CNT_W, default 16, giving the width of the status counters.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all inputs are synchronous to its rising edge.
REQ-005 reset  in  1  synchronous active-low reset (0 = reset).
REQ-006 adc_strb  in  1  one-cycle pulse marking a valid ADC word on the adc_* inputs.
REQ-007 adc_da, adc_db  in  8 each  ADC channel A/B words, offset binary.
REQ-008 adc_dora, adc_dorb  in  1 each  channel A/B overrange flags.
REQ-009 adc_chsel  in  1  mux-mode channel marker: 1 = A word, 0 = B word.
REQ-010 en, cfg_mux, cfg_twos, clr_cnt  in  1 each  capture enable, multiplexed-bus mode, two's-complement output, counter clear.
REQ-011 m_valid, m_ready  out, in  1 each  output stream handshake.
REQ-012 m_a, m_b  out  8 each  channel A/B samples; m_or  out  2  {B,A} overrange flags.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 or_cnt_a, or_cnt_b, drop_cnt, sync_err_cnt  out  CNT_W each  status counters.

Function
REQ-015 A word SHALL be accepted only on a cycle where adc_strb=1 and en=1; all other cycles leave the datapath unchanged.
REQ-016 Accepted words SHALL be registered in one input stage; conversion and pairing act on the registered copy.
REQ-017 With cfg_twos=1 each 8-bit word SHALL have its MSB inverted (offset binary to two's complement); with cfg_twos=0 it passes unchanged.
REQ-018 With cfg_mux=0 each accepted word SHALL form one pair {adc_da, adc_db, adc_dorb, adc_dora}.
REQ-019 With cfg_mux=1 the pairer SHALL have states WAIT_A and HAVE_A; only adc_da and adc_dora are used.
REQ-020 WAIT_A + A word -> store A, go HAVE_A; WAIT_A + B word -> discard it, increment sync_err_cnt, stay WAIT_A.
REQ-021 HAVE_A + B word -> emit pair, go WAIT_A; HAVE_A + A word -> replace stored A, increment sync_err_cnt, stay HAVE_A.
REQ-022 Deasserting en, or any change of cfg_mux, SHALL discard a held A word and force WAIT_A without counting an error.
REQ-023 Latency SHALL be exactly 2 rising edges: strobe sampled at edge 0 -> pair written at edge 1 -> m_valid=1 after edge 1 when the FIFO was empty.
REQ-024 The FIFO SHALL be show-ahead: m_a/m_b/m_or show the head pair while m_valid=1; a pop occurs on each edge with m_valid=1 and m_ready=1.
REQ-025 m_a, m_b and m_or SHALL be 0 whenever m_valid=0.
REQ-026 A push when full with no pop in the same cycle SHALL drop the new pair and increment drop_cnt; a push when full with a pop in the same cycle SHALL be accepted.
REQ-027 A pop when empty SHALL have no effect; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 or_cnt_a/or_cnt_b SHALL increment once per emitted pair (pushed or dropped) whose A/B overrange flag is set.
REQ-029 All counters SHALL saturate at all-ones.
REQ-030 clr_cnt=1 SHALL zero every counter on the next edge and SHALL win over a simultaneous increment.

Reset
REQ-031 With reset=0 at an edge, the FIFO SHALL empty, the pairer go WAIT_A, the input stage be cleared, and all counters zero.
REQ-032 During and after reset, m_valid=0, fifo_level=0 and all data outputs read 0.
REQ-033 A reset that arrives mid-pair or mid-burst SHALL discard all in-flight data.

Structure
REQ-034 A shared package max19506_pkg SHALL hold DATA_W=8, the default CNT_W, the pair struct typedef {a, b, or_a, or_b}, and the pairer state enum.
REQ-035 The FIFO SHALL be a separate sub-module adc_pair_fifo (synchronous, show-ahead, parameterised depth, level output).

Verification
REQ-036 Parallel mode, cfg_twos=1, m_ready=1: strobe da=0x80, db=0xFF -> two edges later m_valid=1, m_a=0x00, m_b=0x7F.
REQ-037 Mux mode: A=0x10 then B=0x20 -> one pair {0x10,0x20}. Sequences B,A,A,B -> sync_err_cnt=2 and one pair holding the second A.
REQ-038 m_ready=0 with FIFO_DEPTH+3 strobes -> fifo_level=FIFO_DEPTH, drop_cnt=3. Then pop and push in the same cycle -> level unchanged, no new drop.
REQ-039 dora=1 on 5 pairs, with clr_cnt asserted in the same cycle as the 5th -> or_cnt_a=0 afterwards.
REQ-040 Force or_cnt_a to all-ones, then give one more overrange pair -> the count holds at all-ones.
REQ-041 Reset asserted in HAVE_A with 2 pairs queued -> m_valid=0 and level 0; the next B word counts as a sync error.
